memory_game_auto_player: RTL and testbench



---
 rtl/memory_game_auto_player.sv | 195 +++++++++++++++++++
 tb/tb_memory_game_auto_player.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_game_auto_player.sv
// Automated opponent for the LED memory game: records the LED pattern the game
// shows, then replays it as timed switch presses; also issues the start chord.
module memory_game_auto_player #(
  parameter int unsigned GAME_LIMIT   = 6,
  parameter int unsigned PRESS_CLKS   = 2500000,
  parameter int unsigned RELEASE_CLKS = 2500000,
  parameter int unsigned QUIET_CLKS   = 75000000
) (
  input  logic                                i_Clk,
  input  logic                                i_Reset,
  input  logic                                i_Start,
  input  logic                                i_LED_1,
  input  logic                                i_LED_2,
  input  logic                                i_LED_3,
  input  logic                                i_LED_4,
  output logic                                o_Switch_1,
  output logic                                o_Switch_2,
  output logic                                o_Switch_3,
  output logic                                o_Switch_4,
  output logic                                o_Busy,
  output logic [$clog2(GAME_LIMIT+1)-1:0]     o_Seq_Len,
  output logic                                o_Overflow
);

  localparam int unsigned LEN_W    = $clog2(GAME_LIMIT + 1);
  localparam int unsigned IDX_W    = (GAME_LIMIT > 1) ? $clog2(GAME_LIMIT) : 1;
  localparam int unsigned MAX_PR   = (PRESS_CLKS > RELEASE_CLKS) ? PRESS_CLKS : RELEASE_CLKS;
  localparam int unsigned MAX_CLKS = (MAX_PR > QUIET_CLKS) ? MAX_PR : QUIET_CLKS;
  localparam int unsigned CNT_W    = (MAX_CLKS > 1) ? $clog2(MAX_CLKS) : 1;

  localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(PRESS_CLKS - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CLKS - 1);
  localparam logic [CNT_W-1:0] QUIET_LAST   = CNT_W'(QUIET_CLKS - 1);
  localparam logic [LEN_W-1:0] LEN_FULL     = LEN_W'(GAME_LIMIT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_PRESS,
    ST_START_RELEASE,
    ST_WATCH,
    ST_PRESS,
    ST_RELEASE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] rd_q, rd_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic [3:0]       sw_q, sw_d;
  logic [3:0]       led_q;
  logic [1:0]       pat_q [GAME_LIMIT];

  logic [3:0]       led_now;
  logic [3:0]       rise;
  logic             cap_valid;
  logic [1:0]       cap_id;
  logic             wr_en;

  assign led_now   = {i_LED_4, i_LED_3, i_LED_2, i_LED_1};
  assign rise      = led_now & ~led_q;
  assign cap_valid = |rise;

  // Lowest-numbered rising LED wins when several rise together
  always_comb begin
    cap_id = 2'd0;
    if (rise[0])      cap_id = 2'd0;
    else if (rise[1]) cap_id = 2'd1;
    else if (rise[2]) cap_id = 2'd2;
    else if (rise[3]) cap_id = 2'd3;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      sw_q    <= 4'b0000;
      led_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      sw_q    <= sw_d;
      led_q   <= led_now;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (wr_en) pat_q[IDX_W'(len_q)] <= cap_id;
  end

  // Next state; the duration counter clears on every transition
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    rd_d    = rd_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    sw_d    = 4'b0000;
    busy_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (i_Start) state_d = ST_START_PRESS;
      end
      ST_START_PRESS: begin
        if (cnt_q == PRESS_LAST) begin
          state_d = ST_START_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_START_RELEASE: begin
        if (cnt_q == RELEASE_LAST) begin
          state_d = ST_WATCH;
          cnt_d   = '0;
          len_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // A capture takes priority over the quiet timeout in the same cycle
      ST_WATCH: begin
        if (cap_valid) begin
          if (len_q < LEN_FULL) begin
            wr_en = 1'b1;
            len_d = len_q + LEN_W'(1);
            cnt_d = '0;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (len_q != '0) begin
          if (cnt_q == QUIET_LAST) begin
            state_d = ST_PRESS;
            cnt_d   = '0;
            rd_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PRESS: begin
        if (cnt_q == PRESS_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (cnt_q == RELEASE_LAST) begin
          cnt_d = '0;
          if (LEN_W'(rd_q) == len_q - LEN_W'(1)) begin
            len_d   = '0;
            state_d = ST_WATCH;
          end else begin
            rd_d    = rd_q + IDX_W'(1);
            state_d = ST_PRESS;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Switch drive follows the state being entered so it is registered in step
    case (state_d)
      ST_START_PRESS: sw_d = 4'b0011;
      ST_PRESS:       sw_d = 4'b0001 << pat_q[rd_d];
      default:        sw_d = 4'b0000;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign o_Switch_1 = sw_q[0];
  assign o_Switch_2 = sw_q[1];
  assign o_Switch_3 = sw_q[2];
  assign o_Switch_4 = sw_q[3];
  assign o_Busy     = busy_q;
  assign o_Seq_Len  = len_q;
  assign o_Overflow = ovf_q;

endmodule

// File: tb/tb_memory_game_auto_player.sv
// Scoreboard bench: stimulus pushes expected switch presses, a negedge monitor
// extracts press runs from the switch outputs and compares them.
module tb_memory_game_auto_player;

  localparam int GL = 6;
  localparam int PC = 4;
  localparam int RC = 3;
  localparam int QC = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] tb_led;
  logic [3:0] led;
  logic [3:0] sw;
  logic       busy;
  logic       ovf;
  logic [2:0] seq_len;

  always #5 clk = ~clk;

  // The game mirrors the switches back onto its LEDs
  assign led = tb_led | sw;

  memory_game_auto_player #(
    .GAME_LIMIT(GL), .PRESS_CLKS(PC), .RELEASE_CLKS(RC), .QUIET_CLKS(QC)
  ) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Start(start),
    .i_LED_1(led[0]), .i_LED_2(led[1]), .i_LED_3(led[2]), .i_LED_4(led[3]),
    .o_Switch_1(sw[0]), .o_Switch_2(sw[1]), .o_Switch_3(sw[2]), .o_Switch_4(sw[3]),
    .o_Busy(busy), .o_Seq_Len(seq_len), .o_Overflow(ovf)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int ovf_model = 0;

  typedef struct {
    logic [3:0] sw;
    int         start;   // -1: not checked
    int         len;
    bit         chained; // follows a press of the same replay
  } press_t;

  press_t     sb[$];
  logic [3:0] ev_mask[$];
  int         ev_hold[$];
  int         ev_gap[$];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowest(input logic [3:0] m);
    for (int b = 0; b < 4; b++) if (m[b]) return b;
    return 0;
  endfunction

  // Monitor: a press is a run of a constant non-zero switch vector
  logic [3:0] mon_prev = 4'b0000;
  int         mon_start = 0;
  int         mon_end = -100;
  press_t     mon_e;
  always @(negedge clk) begin
    if (sw != mon_prev) begin
      if (mon_prev != 4'b0000) begin
        if (sb.size() == 0) begin
          chk("unexpected_press", int'(mon_prev), 0);
        end else begin
          mon_e = sb.pop_front();
          chk("press_switch", int'(mon_prev), int'(mon_e.sw));
          chk("press_len", cyc - mon_start, mon_e.len);
          if (mon_e.start >= 0) chk("press_start", mon_start, mon_e.start);
          if (mon_e.chained) chk("release_gap", mon_start - mon_end, RC);
        end
        mon_end = cyc;
      end
      if (sw != 4'b0000) mon_start = cyc;
      mon_prev = sw;
    end
  end

  task automatic do_start();
    int s;
    chk("busy_before_start", int'(busy), 0);
    start = 1'b1;
    s = cyc;
    sb.push_back('{sw: 4'b0011, start: s + 1, len: PC, chained: 1'b0});
    tick();
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    while (cyc < s + 1 + PC + RC) tick();
    chk("watch_busy", int'(busy), 1);
    chk("watch_seq_len", int'(seq_len), 0);
    chk("watch_switches", int'(sw), 0);
  endtask

  // Drives the queued LED events; reference: captured IDs are the lowest
  // rising LED of each event, first GL kept, replay starts QC cycles after
  // the last capture with PC+RC cycles per entry.
  task automatic run_round(input bit cut_by_reset);
    int n, nexp, c, last_set, end_c, w;
    int sets[$];
    n = ev_mask.size();
    nexp = (n < GL) ? n : GL;
    c = cyc;
    for (int i = 0; i < n; i++) begin
      sets.push_back(c);
      c += ev_hold[i] + ev_gap[i];
    end
    last_set = sets[nexp-1];
    for (int i = 0; i < nexp; i++) begin
      press_t p;
      p.sw      = 4'b0001 << lowest(ev_mask[i]);
      p.start   = (i == 0 && n <= GL) ? last_set + 1 + QC : -1;
      p.len     = cut_by_reset ? 1 : PC;
      p.chained = (i > 0);
      sb.push_back(p);
    end
    if (n > GL) ovf_model = 1;
    for (int i = 0; i < n; i++) begin
      tb_led = ev_mask[i];
      repeat (ev_hold[i]) tick();
      tb_led = 4'b0000;
      repeat (ev_gap[i]) tick();
    end
    chk("seq_len_captured", int'(seq_len), nexp);
    chk("overflow", int'(ovf), ovf_model);
    if (cut_by_reset) return;
    if (n <= GL) begin
      end_c = last_set + 1 + QC + nexp * (PC + RC);
      while (cyc < end_c - 1) tick();
      chk("seq_len_before_end", int'(seq_len), nexp);
      tick();
      chk("seq_len_end", int'(seq_len), 0);
      chk("busy_after_round", int'(busy), 1);
    end else begin
      w = 0;
      while (seq_len != 0 && w < 300) begin
        tick();
        w++;
      end
      chk("replay_done", int'(seq_len), 0);
    end
    repeat (2) tick();
    chk("scoreboard_empty", sb.size(), 0);
    chk("overflow_sticky", int'(ovf), ovf_model);
  endtask

  task automatic clear_events();
    ev_mask.delete();
    ev_hold.delete();
    ev_gap.delete();
  endtask

  task automatic add_event(input logic [3:0] m, input int h, input int g);
    ev_mask.push_back(m);
    ev_hold.push_back(h);
    ev_gap.push_back(g);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int w;
    rst = 1'b1;
    start = 1'b0;
    tb_led = 4'b0000;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_switches", int'(sw), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_seq_len", int'(seq_len), 0);
    chk("reset_overflow", int'(ovf), 0);
    repeat (2) tick();

    do_start();

    // LED3 then LED1, 5 high / 5 low
    clear_events();
    add_event(4'b0100, 5, 5);
    add_event(4'b0001, 5, 5);
    run_round(1'b0);

    // Seven rises: the seventh is dropped and overflow latches
    clear_events();
    for (int i = 0; i < 7; i++) add_event(4'b0001 << (i % 4), 2, 2);
    run_round(1'b0);

    // LED2 and LED4 together: one capture, ID 1
    clear_events();
    add_event(4'b1010, 3, 3);
    run_round(1'b0);

    for (int r = 0; r < 8; r++) begin
      int n;
      if ($urandom_range(0, 1) == 1) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      repeat ($urandom_range(0, 4)) tick();
      clear_events();
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++)
        add_event(4'($urandom_range(1, 15)), $urandom_range(1, 4), $urandom_range(1, 4));
      run_round(1'b0);
    end

    // Reset while o_Switch_2 is pressed during replay
    clear_events();
    add_event(4'b0010, 2, 2);
    run_round(1'b1);
    w = 0;
    while (sw[1] != 1'b1 && w < 100) begin
      tick();
      w++;
    end
    chk("reached_press", int'(sw[1]), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ovf_model = 0;
    chk("midreset_switches", int'(sw), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_seq_len", int'(seq_len), 0);
    chk("midreset_overflow", int'(ovf), 0);
    repeat (2) tick();

    do_start();
    clear_events();
    add_event(4'b1000, 2, 3);
    add_event(4'b0110, 1, 2);
    add_event(4'b0001, 3, 1);
    run_round(1'b0);

    repeat (3) tick();
    chk("final_scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
